// File: rtl/tpu_pkg.sv
// Shared types and sizing for the TPU instruction fetch path.
package tpu_pkg;

    localparam int INSTR_W   = 32;
    localparam int IB_DEPTH  = 32;
    localparam int IB_ADDR_W = $clog2(IB_DEPTH);

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_PRIME = 2'd1,
        IF_RUN   = 2'd2,
        IF_DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_ram_1r1w.sv
// Instruction buffer: one write port, one registered read port.
// A read that hits the address being written returns the new word.
module instr_ram_1r1w #(
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 32,
    parameter int ADDR_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // Storage array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read with write-first bypass; the output register clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/tpu_instr_fetch.sv
// Instruction buffer and sequencer: the loader fills the buffer while idle,
// a start pulse streams prog_len words from pc 0 as a valid/ready stream.
module tpu_instr_fetch #(
    parameter int INSTR_W = tpu_pkg::INSTR_W,
    parameter int DEPTH   = tpu_pkg::IB_DEPTH,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               start,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               abort,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               busy,
    output logic               done,
    output logic               wr_err
);

    import tpu_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W:0]   len;
    logic              fire;
    logic              last;
    logic              accept_start;
    logic              ram_we;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] rd_addr;

    assign accept_start = (state == IF_IDLE) && start;
    assign fire         = (state == IF_RUN) && instr_ready;
    assign last         = ({1'b0, pc} == (len - 1'b1));
    assign pc_inc       = pc + 1'b1;
    // Prefetch the next word on a fire so back-to-back fires need no bubble.
    assign rd_addr      = fire ? pc_inc : pc;
    assign ram_we       = wr_en && (state == IF_IDLE);

    instr_ram_1r1w #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (instr_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IF_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and control outputs; abort wins over fire.
    always_comb begin
        state_nx    = state;
        instr_valid = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IF_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (prog_len != '0) ? IF_PRIME : IF_DONE;
                end
            end
            IF_PRIME: begin
                state_nx = abort ? IF_IDLE : IF_RUN;
            end
            IF_RUN: begin
                instr_valid = 1'b1;
                if (abort) begin
                    state_nx = IF_IDLE;
                end else if (instr_ready && last) begin
                    state_nx = IF_DONE;
                end
            end
            IF_DONE: begin
                done     = 1'b1;
                state_nx = IF_IDLE;
            end
            default: begin
                state_nx = IF_IDLE;
            end
        endcase
    end

    assign instr_pc = pc;

    // Program counter, clamped length and sticky write-while-busy error.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            len    <= '0;
            wr_err <= 1'b0;
        end else begin
            if (accept_start) begin
                pc  <= '0;
                len <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
            end else if ((state != IF_IDLE) && abort) begin
                pc <= '0;
            end else if (fire && !last) begin
                pc <= pc_inc;
            end

            if (wr_en && (state != IF_IDLE)) begin
                wr_err <= 1'b1;
            end else if (accept_start) begin
                wr_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tpu_instr_fetch.sv
// Directed bench for tpu_instr_fetch.
module tb_tpu_instr_fetch;

    localparam int INSTR_W = 32;
    localparam int DEPTH   = 32;
    localparam int ADDR_W  = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic               start;
    logic [ADDR_W:0]    prog_len;
    logic               abort;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic               busy;
    logic               done;
    logic               wr_err;

    int n_tests = 0;
    int n_fail  = 0;

    tpu_instr_fetch #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .prog_len    (prog_len),
        .abort       (abort),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .busy        (busy),
        .done        (done),
        .wr_err      (wr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [INSTR_W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_a_prog();
        for (int i = 0; i < 4; i++) load_word(i, 32'hA0 + 32'(i));
    endtask

    task automatic pulse_start(input int len);
        start    = 1'b1;
        prog_len = (ADDR_W+1)'(len);
        tick();
        start    = 1'b0;
    endtask

    // Tick until done is seen (done visible on return), bounded.
    task automatic run_until_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if ({instr_valid, busy, done, wr_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {instr_valid, busy, done, wr_err});
        end
        n_tests++;
        if (instr_data !== '0 || instr_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got data %h pc %0d expected 0/0", instr_data, instr_pc);
        end
    endtask

    task automatic test_basic_stream();
        load_a_prog();
        instr_ready = 1'b1;
        pulse_start(4);
        n_tests++;
        if (instr_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_prime: got valid %b busy %b expected 0/1", instr_valid, busy);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (instr_valid !== 1'b1 || instr_pc !== ADDR_W'(i) || instr_data !== 32'hA0 + 32'(i)) begin
                n_fail++;
                $display("FAIL basic_word%0d: got v%b pc%0d %h expected v1 pc%0d %h",
                         i, instr_valid, instr_pc, instr_data, i, 32'hA0 + 32'(i));
            end
            tick();
        end
        n_tests++;
        if (done !== 1'b1 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got done %b valid %b expected 1/0", done, instr_valid);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: got done %b busy %b expected 0/0", done, busy);
        end
    endtask

    task automatic test_stall();
        logic [3:0]         pat;
        int                 got;
        bit                 seen_done;
        bit                 prev_stall;
        logic [ADDR_W-1:0]  prev_pc;
        logic [INSTR_W-1:0] prev_data;
        pat        = 4'b1001;
        got        = 0;
        seen_done  = 1'b0;
        prev_stall = 1'b0;
        prev_pc    = '0;
        prev_data  = '0;
        instr_ready = 1'b1;
        pulse_start(4);
        tick();
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (prev_stall) begin
                n_tests++;
                if (instr_valid !== 1'b1 || instr_pc !== prev_pc || instr_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: got v%b pc%0d %h expected v1 pc%0d %h",
                             instr_valid, instr_pc, instr_data, prev_pc, prev_data);
                end
            end
            instr_ready = pat[k % 4];
            if (instr_valid && instr_ready) begin
                n_tests++;
                if (instr_pc !== ADDR_W'(got) || instr_data !== 32'hA0 + 32'(got)) begin
                    n_fail++;
                    $display("FAIL stall_word%0d: got pc%0d %h expected pc%0d %h",
                             got, instr_pc, instr_data, got, 32'hA0 + 32'(got));
                end
                got++;
            end
            prev_stall = instr_valid && !instr_ready;
            prev_pc    = instr_pc;
            prev_data  = instr_data;
            tick();
        end
        instr_ready = 1'b1;
        n_tests++;
        if (!seen_done || got != 4) begin
            n_fail++;
            $display("FAIL stall_count: got done_seen %0d words %0d expected 1/4", seen_done, got);
        end
        tick();
    endtask

    task automatic test_zero_len();
        pulse_start(0);
        n_tests++;
        if ({done, busy, instr_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL zero_len_done: got done/busy/valid %b expected 110", {done, busy, instr_valid});
        end
        tick();
        n_tests++;
        if ({done, busy, instr_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL zero_len_idle: got done/busy/valid %b expected 000", {done, busy, instr_valid});
        end
    endtask

    task automatic test_overflow_len();
        int  count;
        bit  seen_done;
        count     = 0;
        seen_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) load_word(i, 32'h1000 + 32'(i));
        instr_ready = 1'b1;
        pulse_start(40);
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (instr_valid) begin
                if (instr_pc !== ADDR_W'(count) || instr_data !== 32'h1000 + 32'(count)) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ovf_word%0d: got pc%0d %h expected pc%0d %h",
                             count, instr_pc, instr_data, count, 32'h1000 + 32'(count));
                end
                count++;
            end
            tick();
        end
        n_tests++;
        if (!seen_done || count != DEPTH) begin
            n_fail++;
            $display("FAIL ovf_count: got done_seen %0d words %0d expected 1/%0d", seen_done, count, DEPTH);
        end
        tick();
    endtask

    task automatic test_wr_err();
        bit ok;
        load_a_prog();
        instr_ready = 1'b0;
        pulse_start(4);
        tick();
        wr_en   = 1'b1;
        wr_addr = 5'd2;
        wr_data = 32'hFF;
        tick();
        wr_en   = 1'b0;
        n_tests++;
        if (wr_err !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_err_set: got wr_err %b busy %b expected 1/1", wr_err, busy);
        end
        instr_ready = 1'b1;
        run_until_done(ok);
        tick();
        n_tests++;
        if (!ok || wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_err_sticky: got done_seen %0d wr_err %b expected 1/1", ok, wr_err);
        end
        pulse_start(4);
        n_tests++;
        if (wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_err_clear: got %b expected 0", wr_err);
        end
        tick();
        tick();
        tick();
        n_tests++;
        if (instr_pc !== 5'd2 || instr_data !== 32'hA2) begin
            n_fail++;
            $display("FAIL wr_err_mem2: got pc%0d %h expected pc2 000000a2", instr_pc, instr_data);
        end
        run_until_done(ok);
        tick();
    endtask

    task automatic test_abort_and_reset();
        instr_ready = 1'b1;
        pulse_start(4);
        tick();
        tick();
        n_tests++;
        if (instr_pc !== 5'd1 || instr_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup: got pc%0d v%b expected pc1 v1", instr_pc, instr_valid);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++;
        if ({instr_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_idle: got valid/busy/done %b expected 000", {instr_valid, busy, done});
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %b expected 0", done);
        end
        pulse_start(4);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({instr_valid, busy, done} !== 3'b000 || instr_data !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got valid/busy/done %b data %h expected 000 0",
                     {instr_valid, busy, done}, instr_data);
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_done: got %b expected 0", done);
        end
        pulse_start(4);
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 5'd0 || instr_data !== 32'hA0) begin
            n_fail++;
            $display("FAIL restart: got v%b pc%0d %h expected v1 pc0 000000a0", instr_valid, instr_pc, instr_data);
        end
        tick();
        tick();
        tick();
        tick();
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_done: got %b expected 1", done);
        end
        tick();
    endtask

    task automatic test_write_first();
        instr_ready = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hB0;
        start    = 1'b1;
        prog_len = 6'd1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        tick();
        n_tests++;
        if (instr_valid !== 1'b1 || instr_pc !== 5'd0 || instr_data !== 32'hB0) begin
            n_fail++;
            $display("FAIL write_first: got v%b pc%0d %h expected v1 pc0 000000b0", instr_valid, instr_pc, instr_data);
        end
        tick();
        n_tests++;
        if (done !== 1'b1 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_first_done: got done %b valid %b expected 1/0", done, instr_valid);
        end
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        start       = 1'b0;
        prog_len    = '0;
        abort       = 1'b0;
        instr_ready = 1'b1;
        test_reset();
        test_basic_stream();
        test_stall();
        test_zero_len();
        test_overflow_len();
        test_wr_err();
        test_abort_and_reset();
        test_write_first();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
